fp_class_unbox: RTL

Two-stage pipelined FP operand classifier and NaN-unboxer for the FP unit. It accepts a 64-bit register-file operand plus a format bit. Single-precision operands are checked for correct NaN-boxing (upper 32 bits all ones); improperly boxed operands are replaced with the canonical single-precision qNaN. The block then produces the 10-bit RISC-V FCLASS mask. It sits between the FP register read port and the FP execution units and is the inverse of the boxing done on FP results (e.g. sign injection), with valid/ready flow control on both sides.

---
 rtl/fp_class_unbox.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fp_class_unbox.sv
// Two-stage pipelined FP operand classifier: NaN-unboxes single-precision
// operands and produces the RISC-V FCLASS mask, with valid/ready on both sides.
module fp_class_unbox (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_valid,
    output logic        out_ready,
    input  logic [63:0] in_data,
    input  logic        in_fmt,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [63:0] out_data,
    output logic [9:0]  out_class,
    output logic        out_badbox,
    output logic        out_fmt
);

    localparam logic [31:0] SP_BOX  = 32'hFFFF_FFFF;
    localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;

    // Stage 1 state
    logic        s1_valid;
    logic [63:0] s1_data;
    logic        s1_fmt;
    logic        s1_badbox;
    logic        s1_sign;
    logic        s1_exp_ones;
    logic        s1_exp_zero;
    logic        s1_man_zero;
    logic        s1_man_msb;

    // Stage 1 next values
    logic        badbox_d;
    logic [63:0] unboxed_d;
    logic        sign_d;
    logic        exp_ones_d;
    logic        exp_zero_d;
    logic        man_zero_d;
    logic        man_msb_d;
    logic [9:0]  class_d;

    logic s2_can_load;
    logic accept;

    assign s2_can_load = !out_valid || in_ready;
    assign out_ready   = !s1_valid || s2_can_load;
    assign accept      = in_valid && out_ready;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
        badbox_d   = !in_fmt && (in_data[63:32] != SP_BOX);
        unboxed_d  = badbox_d ? {SP_BOX, SP_QNAN} : in_data;
        sign_d     = unboxed_d[31];
        exp_ones_d = &unboxed_d[30:23];
        exp_zero_d = ~|unboxed_d[30:23];
        man_zero_d = ~|unboxed_d[22:0];
        man_msb_d  = unboxed_d[22];
        if (in_fmt) begin
            sign_d     = unboxed_d[63];
            exp_ones_d = &unboxed_d[62:52];
            exp_zero_d = ~|unboxed_d[62:52];
            man_zero_d = ~|unboxed_d[51:0];
            man_msb_d  = unboxed_d[51];
        end
    end

    // A badboxed operand already carries the canonical qNaN fields, so it lands in bit 9.
    always_comb begin
        class_d    = '0;
        class_d[0] =  s1_sign && s1_exp_ones && s1_man_zero;
        class_d[1] =  s1_sign && !s1_exp_ones && !s1_exp_zero;
        class_d[2] =  s1_sign && s1_exp_zero && !s1_man_zero;
        class_d[3] =  s1_sign && s1_exp_zero && s1_man_zero;
        class_d[4] = !s1_sign && s1_exp_zero && s1_man_zero;
        class_d[5] = !s1_sign && s1_exp_zero && !s1_man_zero;
        class_d[6] = !s1_sign && !s1_exp_ones && !s1_exp_zero;
        class_d[7] = !s1_sign && s1_exp_ones && s1_man_zero;
        class_d[8] =  s1_exp_ones && !s1_man_zero && !s1_man_msb;
        class_d[9] =  s1_exp_ones && s1_man_msb;
    end

    // NOTE: datapath registers are reset too, because the outputs have defined reset values.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_fmt      <= 1'b0;
            s1_badbox   <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp_ones <= 1'b0;
            s1_exp_zero <= 1'b0;
            s1_man_zero <= 1'b0;
            s1_man_msb  <= 1'b0;
        end else if (out_ready) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            s1_valid <= in_valid;
            if (accept) begin
                s1_data     <= unboxed_d;
                s1_fmt      <= in_fmt;
                s1_badbox   <= badbox_d;
                s1_sign     <= sign_d;
                s1_exp_ones <= exp_ones_d;
                s1_exp_zero <= exp_zero_d;
                s1_man_zero <= man_zero_d;
                s1_man_msb  <= man_msb_d;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_class  <= '0;
            out_badbox <= 1'b0;
            out_fmt    <= 1'b0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= s1_data;
                out_class  <= class_d;
                out_badbox <= s1_badbox;
                out_fmt    <= s1_fmt;
            end
        end
    end

endmodule
